dac_readback_spi: RTL
=====================

# dac_readback_spi

- Serial readback engine for the AD5754 corrector/BPM test DAC.
- Issues a 24-bit read command frame, then a NOP frame, and captures the 24-bit word the DAC shifts out on SDO during the NOP frame.
- Sits beside the DAC write engine on the same SCLK-rate domain; an external mux selects which engine drives the serial pins, using `busy_o`.
- Returned register contents go to PLB status registers for DAC setup verification.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles (≥1).
- `SYNC_GAP`, default 4: `clk` cycles with SYNC high between command and NOP frames (≥2).
- `clk`  in  1  single clock; all logic on rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  start readback; sampled only in IDLE.
- `reg_sel_i`  in  3  AD5754 REG field.
- `addr_i`  in  3  AD5754 A field (channel/address).
- `busy_o`  out  1  high from accepted request until the last NOP-frame bit completes.
- `done_o`  out  1  one-cycle pulse; read results valid.
- `rd_data_o`  out  16  captured data bits [15:0].
- `rd_raw_o`  out  24  full captured SDO word.
- `mismatch_o`  out  1  echoed REG/A ≠ requested; valid with `done_o`.
- `dacSync`  out  1  active-low frame sync.
- `dacSclk`  out  1  serial clock, idles high.
- `dacSdin`  out  1  serial data to DAC.
- `dacSdo_i`  in  1  serial data from DAC.

## Operation
- States: IDLE → CMD → GAP → NOP → IDLE.
- IDLE: `dacSync`=1, `dacSclk`=1, `dacSdin`=0, `busy_o`=0. On `req_i`=1, latch `reg_sel_i`/`addr_i` and go to CMD.
- Command word: {1'b1, 1'b0, reg_sel, addr, 16'h0000}.
- NOP word: 24'h180000.
- Frame, MSB first:
  - `dacSync` low for the whole frame.
  - Each bit: SCLK high for `CLK_DIV` cycles with the bit on `dacSdin`, then SCLK low for `CLK_DIV` cycles.
  - The DAC samples on the falling edge.
  - Frame length is 48·`CLK_DIV` cycles.
- GAP: `dacSync` high and SCLK high for `SYNC_GAP` cycles.
- SDO capture:
  - Only during NOP.
  - `dacSdo_i` is shifted into a 24-bit register on the `clk` edge that drives `dacSclk` 1→0.
- On exit from NOP:
  - `rd_raw_o` ← captured word; `rd_data_o` ← bits [15:0].
  - `mismatch_o` ← (captured[21:16] ≠ {reg_sel, addr}).
  - `done_o` pulses in the first IDLE cycle.
- `rd_*` and `mismatch_o` hold until the next `done_o`.
- Reset values: `dacSync`=1, `dacSclk`=1, `dacSdin`=0, `busy_o`=0, `done_o`=0, `rd_data_o`=0, `rd_raw_o`=0, `mismatch_o`=0, state IDLE.

## Timing
- All outputs are registered.
- Request accepted at edge T. `dacSync` falls and bit 23 appears in cycle T+1.
- `done_o` asserts exactly 96·`CLK_DIV`+`SYNC_GAP`+2 cycles after T. With defaults: 390.
- `busy_o` rises in T+1 and falls in the same cycle `done_o` pulses.
- `req_i` when not IDLE: ignored, not queued.
- `req_i` in the `done_o` cycle: accepted; back-to-back operation has no dead cycle.
- `dacSdin` changes only on the `clk` edge that drives SCLK 0→1, or at frame start. It is stable across every falling edge.
- Reset asserted mid-frame:
  - Pins go immediately (asynchronously) to idle values.
  - No `done_o`; result registers are cleared.
- Reset released with `req_i` high: the request is accepted on the first rising edge after release.
- `CLK_DIV`=1: SCLK toggles every cycle; latency is 96+`SYNC_GAP`+2.

## Structure
- Shared package `dac_spi_pkg` holds:
  - `FRAME_BITS`=24.
  - `AD5754_NOP`=24'h180000.
  - R/W bit index 23.
  - REG/A field positions.
  - State enum.
- Sub-module `spi_frame_shifter`:
  - Function: load 24-bit word, run one frame, return captured word and a `frame_done` pulse.
  - Inputs: `CLK_DIV`, `start`, `tx_word`, `capture_en`.
  - The top FSM invokes it twice per readback.
  - The DAC write engine can reuse it later.

## Test plan
- Read, reg 000, addr 010:
  - Stimulus: SDO model returns 24'h02ABCD.
  - Required: SDIN frames 24'h820000 then 24'h180000; `rd_data_o`=16'hABCD; `rd_raw_o`=24'h02ABCD; `mismatch_o`=0; `done_o` at T+390.
- Mismatch: model echoes A=001 for request A=010 → `mismatch_o`=1; data still captured.
- `req_i` pulses during CMD and NOP → no extra frames; exactly one `done_o`.
- `Reset_n` low at cycle 100:
  - Pins idle in the same cycle; `busy_o`=0; outputs zero; no `done_o`.
  - Next request completes normally.
- `CLK_DIV`=1, `SYNC_GAP`=2 → `done_o` at T+100; SDO sampled on every 1→0 SCLK edge.
- Back-to-back: `req_i` held high → second command frame's `dacSync` falls the cycle after the first `done_o`; gap between frames of one readback is exactly `SYNC_GAP` cycles.

Source files
------------

// File: rtl/dac_spi_pkg.sv
// Shared constants, frame layout and state encoding for the AD5754 serial engines.
package dac_spi_pkg;

  localparam int FRAME_BITS = 24;
  localparam logic [FRAME_BITS-1:0] AD5754_NOP = 24'h180000;

  localparam int RW_BIT   = 23;
  localparam int REG_MSB  = 21;
  localparam int REG_LSB  = 19;
  localparam int ADDR_MSB = 18;
  localparam int ADDR_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_GAP,
    ST_NOP
  } rb_state_e;

  function automatic logic [FRAME_BITS-1:0] read_cmd(input logic [2:0] reg_sel,
                                                     input logic [2:0] addr);
    logic [FRAME_BITS-1:0] w;
    w                    = '0;
    w[RW_BIT]            = 1'b1;
    w[REG_MSB:REG_LSB]   = reg_sel;
    w[ADDR_MSB:ADDR_LSB] = addr;
    return w;
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Runs one 24-bit SYNC-framed transfer: SCLK idles high, data changes on SCLK rise,
// DAC samples on SCLK fall; optionally captures SDO on each falling edge.
module spi_frame_shifter
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_word,
  input  logic                  capture_en,
  input  logic                  sdo,
  output logic                  sync,
  output logic                  sclk,
  output logic                  sdin,
  output logic [FRAME_BITS-1:0] rx_word,
  output logic                  frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int BIT_W = $clog2(FRAME_BITS);

  logic                  active;
  logic                  cap;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bits_left;
  logic [FRAME_BITS-1:0] tx_sr;

  // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= 1'b0;
      cap        <= 1'b0;
      div_cnt    <= '0;
      bits_left  <= '0;
      tx_sr      <= '0;
      rx_word    <= '0;
      sync       <= 1'b1;
      sclk       <= 1'b1;
      sdin       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!active) begin
        if (start) begin
          active    <= 1'b1;
          cap       <= capture_en;
          div_cnt   <= '0;
          bits_left <= BIT_W'(FRAME_BITS - 1);
          tx_sr     <= {tx_word[FRAME_BITS-2:0], 1'b0};
          sync      <= 1'b0;
          sclk      <= 1'b1;
          sdin      <= tx_word[FRAME_BITS-1];
          if (capture_en) rx_word <= '0;
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (sclk) begin
          // Falling edge: the DAC samples SDIN here and presents its next SDO bit.
          sclk <= 1'b0;
          if (cap) rx_word <= {rx_word[FRAME_BITS-2:0], sdo};
        end else if (bits_left == '0) begin
          active     <= 1'b0;
          sync       <= 1'b1;
          sclk       <= 1'b1;
          sdin       <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          sclk      <= 1'b1;
          sdin      <= tx_sr[FRAME_BITS-1];
          tx_sr     <= {tx_sr[FRAME_BITS-2:0], 1'b0};
          bits_left <= bits_left - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dac_readback_spi.sv
// AD5754 register readback: read-command frame, SYNC gap, NOP frame capturing SDO,
// then a one-cycle done pulse with the captured word and an echo-mismatch flag.
module dac_readback_spi
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SYNC_GAP = 4
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        req_i,
  input  logic [2:0]  reg_sel_i,
  input  logic [2:0]  addr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] rd_data_o,
  output logic [23:0] rd_raw_o,
  output logic        mismatch_o,
  output logic        dacSync,
  output logic        dacSclk,
  output logic        dacSdin,
  input  logic        dacSdo_i
);

  // The NOP frame is launched one edge after the counter expires and CMD's frame_done
  // is seen one edge late, so the counter covers SYNC_GAP-2 cycles.
  localparam int GAP_W = (SYNC_GAP > 2) ? $clog2(SYNC_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SYNC_GAP - 2);

  rb_state_e             state, state_next;
  logic                  start;
  logic                  capture;
  logic                  finish;
  logic [FRAME_BITS-1:0] tx_word;
  logic [FRAME_BITS-1:0] rx_word;
  logic                  frame_done;
  logic [GAP_W-1:0]      gap_cnt;
  logic [5:0]            req_field;

  spi_frame_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (Reset_n),
    .start      (start),
    .tx_word    (tx_word),
    .capture_en (capture),
    .sdo        (dacSdo_i),
    .sync       (dacSync),
    .sclk       (dacSclk),
    .sdin       (dacSdin),
    .rx_word    (rx_word),
    .frame_done (frame_done)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    tx_word    = AD5754_NOP;
    case (state)
      ST_IDLE: if (req_i) begin
        start      = 1'b1;
        tx_word    = read_cmd(reg_sel_i, addr_i);
        state_next = ST_CMD;
      end
      ST_CMD:  if (frame_done) state_next = ST_GAP;
      ST_GAP:  if (gap_cnt == '0) begin
        start      = 1'b1;
        capture    = 1'b1;
        state_next = ST_NOP;
      end
      ST_NOP:  if (frame_done) begin
        finish     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      rd_raw_o   <= '0;
      mismatch_o <= 1'b0;
      req_field  <= '0;
      gap_cnt    <= '0;
    end else begin
      done_o <= finish;
      if (state == ST_IDLE && start) begin
        busy_o    <= 1'b1;
        req_field <= {reg_sel_i, addr_i};
      end
      if (finish) begin
        busy_o     <= 1'b0;
        rd_raw_o   <= rx_word;
        mismatch_o <= (rx_word[REG_MSB:ADDR_LSB] != req_field);
      end
      if (state == ST_CMD && frame_done)         gap_cnt <= GAP_LOAD;
      else if (state == ST_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end

  assign rd_data_o = rd_raw_o[15:0];

endmodule
